// File: rtl/lsu_mem_master.sv
// LSU-side memory initiator: one load/store at a time, dword-aligned byte-masked
// memory port, load extraction/extension, error on misalign, miss or timeout.
module lsu_mem_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [32:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        ioMem_ren,
  output logic [32:0] ioMem_addr,
  input  logic [63:0] ioMem_rData,
  input  logic        ioMem_rvalid,
  input  logic        ioMem_hit,
  output logic        ioMem_wen,
  output logic [63:0] ioMem_wData,
  output logic [7:0]  ioMem_wMask
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic          r_wen;
  logic [1:0]    r_size;
  logic          r_sgn;
  logic [2:0]    r_off;
  logic [63:0]   r_wdata;
  logic [32:0]   r_maddr;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_rdata;
  logic          r_err;

  logic          w_misal;
  logic          w_store;
  logic [63:0]   w_sh;
  logic [63:0]   w_ldata;
  logic [7:0]    w_mask;

  always_comb begin
    w_misal = 1'b0;
    case (req_size)
      2'd0:    w_misal = 1'b0;
      2'd1:    w_misal = req_addr[0];
      2'd2:    w_misal = |req_addr[1:0];
      default: w_misal = |req_addr[2:0];
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then trim and extend.
  always_comb begin
    w_sh    = ioMem_rData >> {r_off, 3'b000};
    w_ldata = w_sh;
    case (r_size)
      2'd0:    w_ldata = r_sgn ? {{56{w_sh[7]}},  w_sh[7:0]}  : {56'd0, w_sh[7:0]};
      2'd1:    w_ldata = r_sgn ? {{48{w_sh[15]}}, w_sh[15:0]} : {48'd0, w_sh[15:0]};
      2'd2:    w_ldata = r_sgn ? {{32{w_sh[31]}}, w_sh[31:0]} : {32'd0, w_sh[31:0]};
      default: w_ldata = w_sh;
    endcase
  end

  always_comb begin
    w_mask = 8'h00;
    case (r_size)
      2'd0:    w_mask = 8'h01;
      2'd1:    w_mask = 8'h03;
      2'd2:    w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
  end

  assign w_store     = (r_state == ISSUE) & r_wen;
  assign req_ready   = reset & (r_state == IDLE);
  assign resp_valid  = (r_state == RESP);
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;
  assign ioMem_addr  = r_maddr;
  assign ioMem_ren   = (r_state == ISSUE) & ~r_wen;
  assign ioMem_wen   = w_store;
  assign ioMem_wMask = w_store ? (w_mask << r_off) : 8'h00;
  assign ioMem_wData = w_store ? (r_wdata << {r_off, 3'b000}) : 64'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wen   <= 1'b0;
      r_size  <= 2'd0;
      r_sgn   <= 1'b0;
      r_off   <= 3'd0;
      r_wdata <= 64'd0;
      r_maddr <= 33'd0;
      r_cnt   <= '0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_wen   <= req_wen;
          r_size  <= req_size;
          r_sgn   <= req_signed;
          r_off   <= req_addr[2:0];
          r_wdata <= req_wdata;
          r_maddr <= {req_addr[32:3], 3'b000};
          if (w_misal) begin
            r_state <= RESP;
            r_err   <= 1'b1;
            r_rdata <= 64'd0;
          end else begin
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt <= '0;
          if (r_wen) begin
            r_state <= RESP;
            r_err   <= 1'b0;
            r_rdata <= 64'd0;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // Data arriving on the final counted cycle still beats the timeout.
          if (ioMem_rvalid) begin
            r_state <= RESP;
            r_err   <= ~ioMem_hit;
            r_rdata <= ioMem_hit ? w_ldata : 64'd0;
          end else if (r_cnt == TO_LAST) begin
            r_state <= RESP;
            r_err   <= 1'b1;
            r_rdata <= 64'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: if (resp_ready) r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed plus randomized requests against an
// arithmetic reference of the load/store/latency rules.
module tb_lsu_mem_master;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [32:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        ioMem_ren, ioMem_rvalid, ioMem_hit, ioMem_wen;
  logic [32:0] ioMem_addr;
  logic [63:0] ioMem_rData, ioMem_wData;
  logic [7:0]  ioMem_wMask;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rv_cyc = -1;

  lsu_mem_master #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ioMem_ren(ioMem_ren), .ioMem_addr(ioMem_addr), .ioMem_rData(ioMem_rData),
    .ioMem_rvalid(ioMem_rvalid), .ioMem_hit(ioMem_hit), .ioMem_wen(ioMem_wen),
    .ioMem_wData(ioMem_wData), .ioMem_wMask(ioMem_wMask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; the memory responder pulses rvalid on its scheduled cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    ioMem_rvalid = (cyc == rv_cyc);
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] d, input int off,
                                           input int n, input logic sgn);
    logic [63:0] v, m;
    v = d >> (8 * off);
    if (n < 8) begin
      m = (64'd1 << (8 * n)) - 64'd1;
      v = v & m;
      if (sgn && v[8*n-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic do_req(input logic wen, input logic [32:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [63:0] wd, input logic [63:0] md,
                        input logic hit, input int lat, input int bp);
    int n, off, exp_lat, nren, nwen, got_lat;
    logic mis, exp_e;
    logic [63:0] exp_d;
    logic [7:0]  exp_m;
    n   = 1 << size;
    off = int'(addr[2:0]);
    mis = (off % n) != 0;
    exp_m = 8'(((1 << n) - 1) << off);
    if (mis)              begin exp_lat = 1;       exp_d = 0; exp_e = 1'b1; end
    else if (wen)         begin exp_lat = 2;       exp_d = 0; exp_e = 1'b0; end
    else if (lat < TO)    begin exp_lat = 3 + lat; exp_d = hit ? ref_load(md, off, n, sgn) : 64'd0; exp_e = ~hit; end
    else                  begin exp_lat = 2 + TO;  exp_d = 0; exp_e = 1'b1; end

    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wd;
    ioMem_rData = md; ioMem_hit = hit;
    cyc = 0; rv_cyc = -1; nren = 0; nwen = 0; got_lat = 0;
    for (int i = 0; i < 20 && got_lat == 0; i++) begin
      tick();
      if (cyc == 1) req_valid = 1'b0;
      if (ioMem_ren) begin
        nren++;
        rv_cyc = cyc + 1 + lat;
        chk("ren_addr", 64'(ioMem_addr), 64'({addr[32:3], 3'b000}));
      end
      if (ioMem_wen) begin
        nwen++;
        chk("wen_addr", 64'(ioMem_addr), 64'({addr[32:3], 3'b000}));
        chk("wmask", 64'(ioMem_wMask), 64'(exp_m));
        chk("wdata", ioMem_wData, wd << (8 * off));
      end else begin
        chk("w_idle", ioMem_wData | 64'(ioMem_wMask), 64'd0);
      end
      if (resp_valid) got_lat = cyc;
    end
    if (got_lat == 0) chk("resp_timeout", 64'd0, 64'd1);
    chk("latency", 64'(got_lat), 64'(exp_lat));
    chk("rdata", resp_rdata, exp_d);
    chk("err", 64'(resp_err), 64'(exp_e));
    chk("ren_pulses", 64'(nren), 64'(!mis && !wen));
    chk("wen_pulses", 64'(nwen), 64'(!mis && wen));
    for (int b = 0; b < bp; b++) begin
      tick();
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_rdata", resp_rdata, exp_d);
      chk("bp_err", 64'(resp_err), 64'(exp_e));
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_mem", 64'({ioMem_ren, ioMem_wen}), 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("hs_valid", 64'(resp_valid), 64'd0);
    chk("hs_ready", 64'(req_ready), 64'd1);
    ioMem_rvalid = 1'b0;
    rv_cyc = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] a;
    logic [1:0]  sz;
    reset = 1'b0;
    req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_signed = 0; req_wdata = 0;
    resp_ready = 0; ioMem_rData = 0; ioMem_rvalid = 0; ioMem_hit = 0;
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp", 64'({resp_valid, resp_err}) | resp_rdata, 64'd0);
    chk("rst_mem", 64'({ioMem_ren, ioMem_wen, ioMem_wMask}) | 64'(ioMem_addr) | ioMem_wData, 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    tick();

    do_req(1'b0, 33'h0_8000_0002, 2'd0, 1'b1, 64'd0, 64'h1122_3344_55F6_7788, 1'b1, 0, 0);
    do_req(1'b0, 33'h0_8000_0002, 2'd0, 1'b0, 64'd0, 64'h1122_3344_55F6_7788, 1'b1, 0, 0);
    do_req(1'b1, 33'h0_8000_0006, 2'd1, 1'b0, 64'hBEEF, 64'd0, 1'b1, 0, 0);
    do_req(1'b0, 33'h0_8000_0002, 2'd2, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0);
    do_req(1'b0, 33'h0_8000_0010, 2'd2, 1'b1, 64'd0, 64'h8765_4321_0000_0000, 1'b1, 4, 2);
    do_req(1'b0, 33'h0_8000_0014, 2'd2, 1'b1, 64'd0, 64'h8765_4321_0000_0000, 1'b1, 5, 3);
    do_req(1'b0, 33'h0_8000_0014, 2'd2, 1'b1, 64'd0, 64'h8765_4321_0000_0000, 1'b1, 3, 0);
    do_req(1'b0, 33'h0_8000_0000, 2'd3, 1'b1, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b1, 0, 5);
    do_req(1'b0, 33'h1_0000_0008, 2'd3, 1'b0, 64'd0, 64'h5555_5555_5555_5555, 1'b0, 1, 1);

    // Reset while the load is waiting for data.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 33'h0_8000_0020; req_size = 2'd2; req_signed = 1'b0;
    rv_cyc = -1; cyc = 0;
    tick(); req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_ready", 64'(req_ready), 64'd0);
    chk("mrst_resp", 64'({resp_valid, resp_err}) | resp_rdata, 64'd0);
    chk("mrst_mem", 64'({ioMem_ren, ioMem_wen, ioMem_wMask}) | 64'(ioMem_addr) | ioMem_wData, 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    tick();
    chk("mrst_rel_ready", 64'(req_ready), 64'd1);
    ioMem_rvalid = 1'b1; ioMem_hit = 1'b1;
    @(posedge clock); #1;
    ioMem_rvalid = 1'b0;
    chk("mrst_late_rv", 64'({resp_valid, ioMem_ren}), 64'd0);
    chk("mrst_late_ready", 64'(req_ready), 64'd1);
    do_req(1'b1, 33'h0_8000_0003, 2'd0, 1'b0, 64'hA5, 64'd0, 1'b1, 0, 0);

    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 33'($urandom()) | (33'($urandom_range(0, 1)) << 32);
      if ($urandom_range(0, 9) < 7) a = a & ~33'((1 << sz) - 1);
      do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
             {$urandom(), $urandom()}, {$urandom(), $urandom()},
             1'($urandom_range(0, 9) < 8), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
